// File: rtl/stepper_phase_decoder_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the stepper phase decoder: the four legal coil
// patterns plus the hold pattern, the decoder state encoding, the direction
// encoding and a helper that classifies an accepted coil pattern.
// -----------------------------------------------------------------------------
package stepper_pkg;

    // Coil patterns, written with the leftmost bit as bit 0 of the bus
    localparam logic [3:0] PH0     = 4'b0011;
    localparam logic [3:0] PH1     = 4'b1001;
    localparam logic [3:0] PH2     = 4'b1100;
    localparam logic [3:0] PH3     = 4'b0110;
    localparam logic [3:0] PH_HOLD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP   = 2'd0,
        DIR_DOWN = 2'd1,
        DIR_STOP = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        PK_LEGAL   = 2'd0,
        PK_HOLD    = 2'd1,
        PK_ILLEGAL = 2'd2
    } pkind_t;

    typedef struct packed {
        pkind_t     kind;
        logic [1:0] idx;
    } pdec_t;

    // Map a coil pattern to its phase index, or flag it as hold / illegal
    function automatic pdec_t phase_decode(input logic [3:0] pat);
        pdec_t d;
        d.kind = PK_ILLEGAL;
        d.idx  = 2'd0;
        case (pat)
            PH0:     begin d.kind = PK_LEGAL; d.idx = 2'd0; end
            PH1:     begin d.kind = PK_LEGAL; d.idx = 2'd1; end
            PH2:     begin d.kind = PK_LEGAL; d.idx = 2'd2; end
            PH3:     begin d.kind = PK_LEGAL; d.idx = 2'd3; end
            PH_HOLD: begin d.kind = PK_HOLD;  d.idx = 2'd0; end
            default: begin d.kind = PK_ILLEGAL; d.idx = 2'd0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_filter.sv
// -----------------------------------------------------------------------------
// phase_filter
// Two-flop synchronizer followed by a stability filter. A pattern that differs
// from the accepted one is accepted on its FILTER_CYCLES-th consecutive
// identical synchronized sample; any change restarts the count.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_phase         raw coil pattern
//   o_pattern       currently accepted pattern
//   o_new_pattern   one-cycle strobe when o_pattern takes a new value
// -----------------------------------------------------------------------------
module phase_filter
    import stepper_pkg::*;
#(
    parameter int FILTER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_phase,
    output logic [3:0] o_pattern,
    output logic       o_new_pattern
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_acc;
    logic             r_new;

    // Synchronize the bus and count how long the candidate has been stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_cand  <= 4'b0000;
            r_cnt   <= '0;
            r_acc   <= 4'b0000;
            r_new   <= 1'b0;
        end else begin
            r_sync1 <= i_phase;
            r_sync2 <= r_sync1;
            r_new   <= 1'b0;
            if (r_sync2 != r_cand) begin
                // this sample is the first of a new candidate run
                r_cand <= r_sync2;
                r_cnt  <= CNT_W'(1);
            end else if (r_cand == r_acc) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_W'(FILTER_CYCLES - 1)) begin
                r_acc <= r_cand;
                r_new <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pattern     = r_acc;
    assign o_new_pattern = r_new;

endmodule

// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
// Watches the coil-phase bus of a stepper motor and recovers direction, step
// events, signed position and step period; flags skipped and illegal patterns.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   phase_in        observed coil pattern (bit 0 leftmost)
//   clear_fault     pulse: leave FAULT, clear sticky error flags
//   pos_clear       pulse: zero the position counter
//   step_pulse      one-cycle pulse per decoded step
//   dir_out         direction of last step (0 up, 1 down)
//   position        signed step count, wraps
//   last_period     cycles between the last two steps, saturating
//   moving          steps seen within IDLE_TIMEOUT cycles
//   hold            accepted pattern is 1111
//   err_skip        sticky: phase jumped by two
//   err_illegal     sticky: illegal pattern accepted
//   state_out       IDLE=0, TRACK=1, HOLD=2, FAULT=3
// -----------------------------------------------------------------------------
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int FILTER_CYCLES = 16,
    parameter int POS_W         = 16,
    parameter int PER_W         = 24,
    parameter int IDLE_TIMEOUT  = 600000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:3]       phase_in,
    input  logic             clear_fault,
    input  logic             pos_clear,
    output logic             step_pulse,
    output logic             dir_out,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] last_period,
    output logic             moving,
    output logic             hold,
    output logic             err_skip,
    output logic             err_illegal,
    output logic [1:0]       state_out
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [3:0]        w_pattern;
    logic              w_new;
    pdec_t             w_dec;
    logic [1:0]        w_delta;
    logic              w_step;
    dir_t              w_dir;
    logic              w_skip;
    logic              w_ill;
    logic              w_load;
    state_t            w_next_state;

    state_t            r_state;
    logic [1:0]        r_last_idx;
    logic              r_idx_valid;
    logic              r_per_valid;
    logic [PER_W-1:0]  r_per_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    phase_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_phase       (phase_in),
        .o_pattern     (w_pattern),
        .o_new_pattern (w_new)
    );

    assign w_dec   = phase_decode(w_pattern);
    assign w_delta = w_dec.idx - r_last_idx;

    // Decide the reaction to a newly accepted pattern
    always_comb begin
        w_step       = 1'b0;
        w_dir        = DIR_STOP;
        w_skip       = 1'b0;
        w_ill        = 1'b0;
        w_load       = 1'b0;
        w_next_state = r_state;
        if (clear_fault && (r_state == ST_FAULT)) begin
            w_next_state = ST_IDLE;
        end else if (w_new && (r_state != ST_FAULT)) begin
            case (w_dec.kind)
                PK_HOLD: begin
                    w_next_state = ST_HOLD;
                end
                PK_LEGAL: begin
                    w_next_state = ST_TRACK;
                    if (!r_idx_valid) begin
                        // no reference phase yet: adopt this one silently
                        w_load = 1'b1;
                    end else begin
                        case (w_delta)
                            2'd1: begin w_step = 1'b1; w_dir = DIR_UP;   w_load = 1'b1; end
                            2'd3: begin w_step = 1'b1; w_dir = DIR_DOWN; w_load = 1'b1; end
                            2'd2: begin w_skip = 1'b1; w_next_state = ST_FAULT; end
                            default: begin w_load = 1'b0; end
                        endcase
                    end
                end
                default: begin
                    w_ill        = 1'b1;
                    w_next_state = ST_FAULT;
                end
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // State, position, flags, period and activity tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_idx  <= 2'd0;
            r_idx_valid <= 1'b0;
            r_per_valid <= 1'b0;
            r_per_cnt   <= '0;
            r_idle_cnt  <= '0;
            step_pulse  <= 1'b0;
            dir_out     <= 1'b0;
            position    <= '0;
            last_period <= '0;
            moving      <= 1'b0;
            hold        <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            hold       <= (w_next_state == ST_HOLD);
            step_pulse <= w_step;

            if (clear_fault && (r_state == ST_FAULT)) begin
                r_idx_valid <= 1'b0;
            end else if (w_load) begin
                r_last_idx  <= w_dec.idx;
                r_idx_valid <= 1'b1;
            end else begin
                r_idx_valid <= r_idx_valid;
            end

            if (w_step) begin
                dir_out <= (w_dir == DIR_DOWN);
            end else begin
                dir_out <= dir_out;
            end

            // a clear in the same cycle as a step yields exactly +/-1
            if (w_step) begin
                if (w_dir == DIR_DOWN) begin
                    position <= (pos_clear ? '0 : position) - POS_W'(1);
                end else begin
                    position <= (pos_clear ? '0 : position) + POS_W'(1);
                end
            end else if (pos_clear) begin
                position <= '0;
            end else begin
                position <= position;
            end

            // a flag raised in the same cycle as a clear stays set
            err_skip    <= (err_skip & ~clear_fault) | w_skip;
            err_illegal <= (err_illegal & ~clear_fault) | w_ill;

            if (w_step) begin
                r_per_cnt <= PER_W'(1);
                if (r_per_valid) begin
                    last_period <= r_per_cnt;
                end else begin
                    last_period <= last_period;
                end
            end else if (r_per_cnt != {PER_W{1'b1}}) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end else begin
                r_per_cnt <= r_per_cnt;
            end

            // the first step after reset or a fault clear has no valid interval
            if (clear_fault) begin
                r_per_valid <= 1'b0;
            end else if (w_step) begin
                r_per_valid <= 1'b1;
            end else begin
                r_per_valid <= r_per_valid;
            end

            if (w_step) begin
                r_idle_cnt <= '0;
                moving     <= 1'b1;
            end else if (r_idle_cnt < IDLE_W'(IDLE_TIMEOUT)) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                if (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                    moving <= 1'b0;
                end else begin
                    moving <= moving;
                end
            end else begin
                moving <= moving;
            end
        end
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
module tb_stepper_phase_decoder;

    localparam int FC   = 16;
    localparam int PW   = 4;
    localparam int PERW = 24;
    localparam int IT   = 400;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [0:3]      phase_in;
    logic            clear_fault;
    logic            pos_clear;
    logic            step_pulse;
    logic            dir_out;
    logic [PW-1:0]   position;
    logic [PERW-1:0] last_period;
    logic            moving;
    logic            hold;
    logic            err_skip;
    logic            err_illegal;
    logic [1:0]      state_out;

    stepper_phase_decoder #(
        .FILTER_CYCLES (FC),
        .POS_W         (PW),
        .PER_W         (PERW),
        .IDLE_TIMEOUT  (IT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_in    (phase_in),
        .clear_fault (clear_fault),
        .pos_clear   (pos_clear),
        .step_pulse  (step_pulse),
        .dir_out     (dir_out),
        .position    (position),
        .last_period (last_period),
        .moving      (moving),
        .hold        (hold),
        .err_skip    (err_skip),
        .err_illegal (err_illegal),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dir;
        int pos;
        int per;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   last_c0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every step pulse must match the oldest expectation
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("step_cycle", cyc, mon_e.at);
                chk("step_dir", int'(dir_out), mon_e.dir);
                chk("step_pos", int'($signed(position)), mon_e.pos);
                chk("step_period", int'(last_period), mon_e.per);
            end
        end
    end

    // Drive a pattern for hold_n cycles; optionally expect a step from it
    task automatic apply(input logic [3:0] pat, input int hold_n, input bit step,
                         input int d, input int p, input int per, input bit clr_at_step);
        int   c0;
        exp_t e;
        phase_in = pat;
        c0 = cyc;
        last_c0 = c0;
        if (step) begin
            e.dir = d;
            e.pos = p;
            e.per = per;
            e.at  = c0 + FC + 3;
            q.push_back(e);
        end
        for (int i = 0; i < hold_n; i++) begin
            pos_clear = (clr_at_step && (cyc == c0 + FC + 2));
            @(negedge clk);
        end
        pos_clear = 1'b0;
    endtask

    task automatic pulse_clear_fault();
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
    endtask

    task automatic pulse_pos_clear();
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step"},   int'(step_pulse), 0);
        chk({tag, "_dir"},    int'(dir_out), 0);
        chk({tag, "_pos"},    int'($signed(position)), 0);
        chk({tag, "_period"}, int'(last_period), 0);
        chk({tag, "_moving"}, int'(moving), 0);
        chk({tag, "_hold"},   int'(hold), 0);
        chk({tag, "_eskip"},  int'(err_skip), 0);
        chk({tag, "_eill"},   int'(err_illegal), 0);
        chk({tag, "_state"},  int'(state_out), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] wrap_pat [8];
    int         wrap_pos [8];

    initial begin
        wrap_pat = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011};
        wrap_pos = '{1, 2, 3, 4, 5, 6, 7, -8};
        rst_n       = 1'b0;
        phase_in    = 4'b0000;
        clear_fault = 1'b0;
        pos_clear   = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Up sweep
        apply(4'b0011, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t1_state_track", int'(state_out), 1);
        apply(4'b1001, 100, 1'b1, 0, 1, 0, 1'b0);
        apply(4'b1100, 100, 1'b1, 0, 2, 100, 1'b0);
        apply(4'b0110, 100, 1'b1, 0, 3, 100, 1'b0);
        apply(4'b0011, 100, 1'b1, 0, 4, 100, 1'b0);
        chk("t1_pos", int'($signed(position)), 4);
        chk("t1_dir", int'(dir_out), 0);
        chk("t1_period", int'(last_period), 100);
        chk("t1_moving", int'(moving), 1);

        // Down sweep, hold, resume from hold
        apply(4'b0110, 100, 1'b1, 1, 3, 100, 1'b0);
        pulse_pos_clear();
        chk("t2_pos_clear", int'($signed(position)), 0);
        apply(4'b1100, 100, 1'b1, 1, -1, 101, 1'b0);
        apply(4'b1001, 100, 1'b1, 1, -2, 100, 1'b0);
        apply(4'b0011, 100, 1'b1, 1, -3, 100, 1'b0);
        apply(4'b0110, 100, 1'b1, 1, -4, 100, 1'b0);
        chk("t2_pos", int'($signed(position)), -4);
        chk("t2_dir", int'(dir_out), 1);
        apply(4'b1111, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t2_hold", int'(hold), 1);
        chk("t2_state_hold", int'(state_out), 2);
        chk("t2_hold_pos", int'($signed(position)), -4);
        apply(4'b1100, 100, 1'b1, 1, -5, 200, 1'b0);
        chk("t2_state_track", int'(state_out), 1);
        chk("t2_hold_off", int'(hold), 0);
        // pos_clear on the same edge as a down step
        apply(4'b1001, 100, 1'b1, 1, -1, 100, 1'b1);
        chk("t2_clr_step_pos", int'($signed(position)), -1);

        // Glitch rejection
        apply(4'b0011, 100, 1'b1, 1, -2, 100, 1'b0);
        apply(4'b1001, 10, 1'b0, 0, 0, 0, 1'b0);
        apply(4'b0011, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t3_pos", int'($signed(position)), -2);

        // Skip fault
        apply(4'b1100, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t4_eskip", int'(err_skip), 1);
        chk("t4_state_fault", int'(state_out), 3);
        chk("t4_eill", int'(err_illegal), 0);
        apply(4'b1001, 100, 1'b0, 0, 0, 0, 1'b0);
        apply(4'b1100, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t4_frozen_pos", int'($signed(position)), -2);
        pulse_clear_fault();
        chk("t4_state_idle", int'(state_out), 0);
        chk("t4_eskip_clr", int'(err_skip), 0);
        apply(4'b0110, 100, 1'b0, 0, 0, 0, 1'b0);
        chk("t4_state_reload", int'(state_out), 1);
        // first step after clear_fault keeps the old period
        apply(4'b0011, 100, 1'b1, 0, -1, 100, 1'b0);

        // Illegal pattern
        apply(4'b0000, 20, 1'b0, 0, 0, 0, 1'b0);
        chk("t5_eill", int'(err_illegal), 1);
        chk("t5_state_fault", int'(state_out), 3);
        pulse_clear_fault();
        chk("t5_state_idle", int'(state_out), 0);
        chk("t5_eill_clr", int'(err_illegal), 0);

        // Wrap and idle timeout
        pulse_pos_clear();
        chk("t6_pos_zero", int'($signed(position)), 0);
        apply(4'b0011, 50, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(wrap_pat[i], 50, 1'b1, 0, wrap_pos[i], (i == 0) ? 100 : 50, 1'b0);
        end
        chk("t6_wrap_pos", int'($signed(position)), -8);
        chk("t6_moving", int'(moving), 1);
        while (cyc < last_c0 + FC + 3 + IT - 1) @(negedge clk);
        chk("t6_moving_edge", int'(moving), 1);
        @(negedge clk);
        chk("t6_moving_off", int'(moving), 0);
        chk("t6_state", int'(state_out), 1);

        // Reset in the middle of activity
        apply(4'b1001, 40, 1'b1, 0, -7, 419, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("midreset");
        repeat (5) @(negedge clk);
        chk("pending_steps", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
Monitors the 4-bit coil-phase bus driven to the stepper motor and recovers motion from it: direction, step events, signed position and step period. It sits on the observed side of the motor interface as a position and health monitor. It flags skipped or illegal phase patterns so the host can detect lost steps.

Parameters:
FILTER_CYCLES, 16, consecutive identical synchronized samples required to accept a new pattern (min 2)
POS_W, 16, width of signed position counter
PER_W, 24, width of step-period counter
IDLE_TIMEOUT, 600000, cycles without a step before moving deasserts

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
phase_in  in  [0:3]  observed coil pattern; bit 0 leftmost as written
clear_fault  in  1  one-cycle pulse; clears FAULT state and sticky error flags
pos_clear  in  1  one-cycle pulse; sets position to 0
step_pulse  out  1  one-cycle pulse per decoded step
dir_out  out  1  direction of last step; 0 = up, 1 = down
position  out  POS_W  signed step count; up +1, down -1
last_period  out  PER_W  cycles between the last two steps, saturating
moving  out  1  high while steps occur within IDLE_TIMEOUT
hold  out  1  high while accepted pattern is 1111
err_skip  out  1  sticky; phase jumped by 2
err_illegal  out  1  sticky; accepted pattern not in the legal set
state_out  out  2  IDLE=0, TRACK=1, HOLD=2, FAULT=3

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0, state IDLE, filter and counters cleared, last phase index invalid.
- Input path: 2-flop synchronizer, then a stability filter. A candidate differing from the currently accepted pattern is accepted on the FILTER_CYCLES-th consecutive identical sample. Any mismatch restarts the count.
- Latency: an input change held stable gives step_pulse/position update exactly FILTER_CYCLES+3 edges later.
- Phase map: 0011→0, 1001→1, 1100→2, 0110→3. 1111 means HOLD. Every other pattern, including 0000, is ILLEGAL.
- delta = (new_idx − last_idx) mod 4, 2-bit wrap. Result by delta:
  - 1: up step. step_pulse=1, dir_out=0, position+1.
  - 3: down step. step_pulse=1, dir_out=1, position−1.
  - 0: no action.
  - 2: err_skip=1, go to FAULT, no step counted.
- Direction changes need no dead time; delta alone decides each step.
- State machine:
  - IDLE: the first legal index is loaded as last_idx with no step, then go to TRACK. 1111 → HOLD. ILLEGAL → FAULT.
  - TRACK: steps decoded as above. 1111 → HOLD. ILLEGAL → err_illegal, FAULT.
  - HOLD: hold=1, last_idx retained. A legal index is decoded against the retained last_idx, then go to TRACK. ILLEGAL → FAULT.
  - FAULT: steps ignored, position frozen. clear_fault → IDLE with last_idx invalid; err_skip and err_illegal cleared.
- clear_fault in any state other than FAULT: clears the sticky flags only.
- position: two's-complement wrap at ±2^(POS_W−1), no saturation.
- pos_clear coincident with a step: result = 0 ± 1, the step is applied after the clear.
- Period counter: increments every cycle, saturates at all-ones.
  - On each step: last_period ← counter value, counter ← 1.
  - The first step after reset or after clear_fault does not update last_period.
- Idle counter: reset on each step. When it reaches IDLE_TIMEOUT, moving=0. moving=1 on the cycle after any step.
- Reset mid-operation fully reinitializes everything; no state survives.

Decomposition:
- Shared package stepper_pkg:
  - phase pattern constants (PH0..PH3, PH_HOLD)
  - state enum/localparams
  - dir encoding: 0 up, 1 down, 2 stop
- Sub-module phase_filter: synchronizer plus stability filter, parameter FILTER_CYCLES. Outputs accepted pattern and a one-cycle new_pattern strobe.

Test Plan:
1. Up sweep: after reset, 0011 → 1001 → 1100 → 0110 → 0011, each held 100 cycles, FILTER_CYCLES=16 → 4 step_pulses, dir_out=0, position=4, last_period=100, each pulse at input change + 19 edges.
2. Down sweep: 0110 → 1100 → 1001 → 0011 → 0110, then HOLD 1111 → position=−4, dir_out=1, hold=1. Next 1100 → step down, position=−5, state TRACK.
3. Glitch: a 10-cycle 1001 pulse inside a stable 0011 → no step_pulse, position unchanged.
4. Skip: 0011 → 1100 → err_skip=1, state FAULT. Further legal steps do not change position. clear_fault → IDLE, flags 0.
5. Illegal: 0000 stable for 20 cycles from TRACK → err_illegal=1, FAULT.
6. Wrap and timeout: POS_W=4, 8 up-steps from 0 → position=−8 (1000b). No steps for IDLE_TIMEOUT cycles → moving=0. rst_n low for one edge mid-run → all outputs 0.
